// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
//
// Purpose: state encoding, default operand width and bit-counter width helper
//          used by serial_subtractor and its interface.
// Ports:   none (package).
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/busy/done handshake and operand/result bus
//
// Purpose: bundles the handshake and data signals between the sequencing FSM
//          (master) and serial_subtractor (slave).
// Signals: start_i, A_i, B_i (master -> slave); busy_o, done_o, D_o, Bw_o and,
//          with SERIAL_SUB_SIGNED_OVF_EN defined, Ov_o (slave -> master).
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);

  logic             start_i;
  logic [WIDTH-1:0] A_i;
  logic [WIDTH-1:0] B_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] D_o;
  logic             Bw_o;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             Ov_o;
`endif

  modport master (
    output start_i, A_i, B_i,
    input  busy_o, done_o, D_o, Bw_o
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , input Ov_o
`endif
  );

  modport slave (
    input  start_i, A_i, B_i,
    output busy_o, done_o, D_o, Bw_o
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    , output Ov_o
`endif
  );

endinterface

// File: rtl/serial_subtractor_full_adder.sv
// rtl/serial_subtractor_full_adder.sv - one-bit full-adder cell
//
// Purpose: combinational one-bit full adder.
// Ports:   a_i, b_i, c_i (addends and carry in); s_o (sum), c_o (carry out).
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor D = A - B
//
// Purpose: computes A + ~B + 1 one bit per clock, LSB first, through a single
//          full_adder with a registered carry.
// Ports:   clk_i (rising-edge clock), rst_i (synchronous active-high reset),
//          bus (serial_subtractor_if.slave: start_i, A_i, B_i, busy_o, done_o,
//          D_o, Bw_o, and Ov_o when SERIAL_SUB_SIGNED_OVF_EN is defined).
// Option:  SERIAL_SUB_SIGNED_OVF_EN adds the signed-overflow result Ov_o.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serial_subtractor_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] d_q;
  logic             bw_q;
  logic             done_q;
  logic             sum, c_out;
  logic             accept, last_bit, finish;

  full_adder u_fa (
    .a_i (a_sr[0]),
    .b_i (b_sr[0]),
    .c_i (carry),
    .s_o (sum),
    .c_o (c_out)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // The cycle after DONE (done_o high) still counts as busy, so IDLE holds off
  // a new start until done_o has dropped.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last_bit   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i && !done_q) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last_bit   = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      d_q    <= '0;
      bw_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= finish;
      if (accept) begin
        // Subtraction as A + ~B + 1: invert B here, seed the carry with 1.
        a_sr   <= bus.A_i;
        b_sr   <= ~bus.B_i;
        res_sr <= '0;
        carry  <= 1'b1;
        cnt    <= '0;
      end else if (state == RUN) begin
        res_sr <= {sum, res_sr[WIDTH-1:1]};
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        carry  <= c_out;
        cnt    <= cnt + CW'(1);
      end
      if (finish) begin
        d_q  <= res_sr;
        bw_q <= ~carry;
      end
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic cin_msb;
  logic ov_q;

  // Carry into the MSB is the carry register just before the final bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cin_msb <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      if (last_bit) cin_msb <= carry;
      if (finish)   ov_q    <= cin_msb ^ carry;
    end
  end

  assign bus.Ov_o = ov_q;
`endif

  assign bus.busy_o = (state != IDLE) || done_q;
  assign bus.done_o = done_q;
  assign bus.D_o    = d_q;
  assign bus.Bw_o   = bw_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - self-checking bench for serial_subtractor
module tb_serial_subtractor;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifc.slave)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // Timing-level reference: an accepted start at edge e yields done_o after
  // edge e+W+1, busy over edges e..e+W+1, next acceptance no earlier than e+W+3.
  int           e      = 0;
  int           acc_e  = -100;
  int           done_e = -100;
  int           free_e = 0;
  logic [W-1:0] pa, pb;
  logic [W-1:0] m_d    = '0;
  logic         m_bw   = 1'b0;
  logic         m_done = 1'b0;
  logic         m_busy = 1'b0;
  logic         mdl_on = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic         m_ov   = 1'b0;
`endif

  always @(posedge clk) begin
    e++;
    if (rst) begin
      acc_e  = -100;
      done_e = -100;
      free_e = e + 1;
      m_d    = '0;
      m_bw   = 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      m_ov   = 1'b0;
`endif
    end else begin
      if (e == done_e) begin
        m_d  = W'(int'(pa) - int'(pb));
        m_bw = (pa < pb);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        m_ov = ((sx(pa) - sx(pb)) > (2**(W-1) - 1)) || ((sx(pa) - sx(pb)) < -(2**(W-1)));
`endif
      end
      if (ifc.start_i && e >= free_e) begin
        pa     = ifc.A_i;
        pb     = ifc.B_i;
        acc_e  = e;
        done_e = e + W + 1;
        free_e = e + W + 3;
      end
    end
    m_done = !rst && (e == done_e);
    m_busy = !rst && (e >= acc_e) && (e <= acc_e + W + 1);
    mdl_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("busy_o", 32'(ifc.busy_o), 32'(m_busy));
      chk("done_o", 32'(ifc.done_o), 32'(m_done));
      chk("D_o",    32'(ifc.D_o),    32'(m_d));
      chk("Bw_o",   32'(ifc.Bw_o),   32'(m_bw));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      chk("Ov_o",   32'(ifc.Ov_o),   32'(m_ov));
`endif
    end
  end

  // One start pulse from idle; returns the edge count from acceptance to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clk);
    ifc.start_i = 1'b1;
    ifc.A_i     = a;
    ifc.B_i     = b;
    @(posedge clk);
    @(negedge clk);
    ifc.start_i = 1'b0;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ifc.done_o) break;
    end
    if (!ifc.done_o) chk("done_timeout", 32'(0), 32'(1));
    repeat (3) @(negedge clk);
  endtask

  int lat;
  int dn_cnt;
  int dn_last;

  initial begin
    ifc.start_i = 1'b0;
    ifc.A_i     = '0;
    ifc.B_i     = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(ifc.busy_o), 32'(0));
    chk("rst_done", 32'(ifc.done_o), 32'(0));
    chk("rst_D",    32'(ifc.D_o),    32'(0));
    chk("rst_Bw",   32'(ifc.Bw_o),   32'(0));
    rst = 1'b0;

    run_op(4'd9, 4'd3, lat);
    chk("lat_9_3", 32'(lat), 32'(W + 1));
    chk("D_9_3", 32'(ifc.D_o), 32'h6);
    chk("Bw_9_3", 32'(ifc.Bw_o), 32'(0));
    chk("model_D_9_3", 32'(m_d), 32'h6);
    run_op(4'd3, 4'd9, lat);
    chk("D_3_9", 32'(ifc.D_o), 32'hA);
    chk("Bw_3_9", 32'(ifc.Bw_o), 32'(1));
    chk("model_Bw_3_9", 32'(m_bw), 32'(1));
    run_op(4'd0, 4'd0, lat);
    chk("D_0_0", 32'(ifc.D_o), 32'h0);
    chk("Bw_0_0", 32'(ifc.Bw_o), 32'(0));
    run_op(4'd15, 4'd15, lat);
    chk("D_15_15", 32'(ifc.D_o), 32'h0);
    chk("Bw_15_15", 32'(ifc.Bw_o), 32'(0));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    run_op(4'h8, 4'h1, lat);
    chk("D_8_1", 32'(ifc.D_o), 32'h7);
    chk("Ov_8_1", 32'(ifc.Ov_o), 32'(1));
    chk("model_Ov_8_1", 32'(m_ov), 32'(1));
    run_op(4'h7, 4'h1, lat);
    chk("D_7_1", 32'(ifc.D_o), 32'h6);
    chk("Ov_7_1", 32'(ifc.Ov_o), 32'(0));
`endif

    // start and operand changes while running must be ignored
    @(negedge clk);
    ifc.start_i = 1'b1; ifc.A_i = 4'd9; ifc.B_i = 4'd3;
    @(negedge clk);
    ifc.start_i = 1'b0;
    @(negedge clk);
    ifc.start_i = 1'b1; ifc.A_i = 4'd0; ifc.B_i = 4'd15;
    repeat (2) @(negedge clk);
    ifc.start_i = 1'b0;
    for (int i = 0; i < 20 && !ifc.done_o; i++) @(negedge clk);
    chk("ign_done", 32'(ifc.done_o), 32'(1));
    chk("ign_D", 32'(ifc.D_o), 32'h6);
    chk("ign_busy", 32'(ifc.busy_o), 32'(1));
    @(negedge clk);
    chk("ign_busy_fall", 32'(ifc.busy_o), 32'(0));
    repeat (3) @(negedge clk);

    // reset in the second RUN cycle discards the partial result
    ifc.start_i = 1'b1; ifc.A_i = 4'd12; ifc.B_i = 4'd7;
    @(negedge clk);
    ifc.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(ifc.busy_o), 32'(0));
    chk("mid_rst_done", 32'(ifc.done_o), 32'(0));
    chk("mid_rst_D",    32'(ifc.D_o),    32'(0));
    chk("mid_rst_Bw",   32'(ifc.Bw_o),   32'(0));
    dn_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.done_o) dn_cnt++;
    end
    chk("mid_rst_no_done", 32'(dn_cnt), 32'(0));
    run_op(4'd5, 4'd2, lat);
    chk("D_5_2", 32'(ifc.D_o), 32'h3);
    chk("lat_5_2", 32'(lat), 32'(W + 1));

    // start held high: completions spaced W+3 cycles apart
    ifc.start_i = 1'b1; ifc.A_i = 4'd11; ifc.B_i = 4'd4;
    dn_cnt = 0; dn_last = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifc.done_o) begin
        if (dn_last >= 0) chk("held_spacing", 32'(c - dn_last), 32'(W + 3));
        chk("held_D", 32'(ifc.D_o), 32'h7);
        dn_last = c;
        dn_cnt++;
      end
    end
    chk("held_done_count", 32'(dn_cnt >= 2), 32'(1));
    ifc.start_i = 1'b0;
    repeat (10) @(negedge clk);

    // randomized traffic against the reference
    for (int it = 0; it < 60; it++) begin
      int hi;
      int lo;
      hi = $urandom_range(1, 10);
      lo = $urandom_range(0, 8);
      for (int k = 0; k < hi; k++) begin
        ifc.start_i = 1'b1;
        ifc.A_i = W'($urandom);
        ifc.B_i = W'($urandom);
        @(negedge clk);
      end
      ifc.start_i = 1'b0;
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      repeat (lo) @(negedge clk);
    end
    repeat (12) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
